mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the core datapath and a word-wide data
//   memory. Adds byte/halfword/word loads (sign or zero extended) and stores;
//   sub-word stores are done as read-modify-write over the word-only port.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned half/word requests pulse err and touch no memory
//     undefined : err tied 0, offending low address bits are ignored
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     req               access request (sampled only in IDLE)
//     we                1 = store, 0 = load
//     size              00 byte, 01 half, 10/11 word
//     sign_ext          loads: 1 sign-extend, 0 zero-extend
//     addr, wdata       byte address, low-aligned store data
//     busy, done, err   handshake / status outputs (done, err are 1-cycle pulses)
//     rdata             registered extended load result
//     mem_addr, mem_we, mem_wd, mem_rd   word-aligned data memory port
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sx_q, sx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;   // only byte/half stores need the latched data
    logic [DATA_W-1:0]   wbuf_q, wbuf_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                misaligned;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   loaded;

    // Misalignment of the incoming request; only acted on when trapping is built in.
    assign misaligned = ((size == 2'b01) && addr[0]) ||
                        (size[1] && (addr[1:0] != 2'b00));

    // Lane selection: byte lane = addr[1:0], half lane = addr[1], word = lane 0.
    assign byte_v = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    assign half_v = mem_rd[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        merged = mem_rd;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   loaded = {{24{sx_q & byte_v[7]}}, byte_v};
            2'b01:   loaded = {{16{sx_q & half_v[15]}}, half_v};
            default: loaded = mem_rd;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sx_d    = sx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sx_d    = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata[15:0];
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else
`endif
                    if (we && size[1]) begin
                        wbuf_d  = wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (we_q) begin
                    wbuf_d  = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = loaded;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            sx_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sx_q    <= sx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign mem_addr = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    // Gated by rst so a reset during the write cycle suppresses the commit.
    assign mem_we   = (state_q == S_WR) && !rst;
    assign mem_wd   = (state_q == S_WR) ? wbuf_q : '0;

`ifdef MISALIGN_TRAP_EN
    assign err = err_q;
`else
    assign err = 1'b0;
    logic unused_err;
    assign unused_err = err_q ^ misaligned;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    // Word-wide data memory (16 words, upper address bits alias).
    logic [31:0] tmem [0:15];
    int          wr_cnt = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    int          done_cnt = 0;
    int          err_cnt = 0;

    assign mem_rd = tmem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            tmem[mem_addr[5:2]] <= mem_wd;
            wr_cnt  = wr_cnt + 1;
            last_wa = mem_addr;
            last_wd = mem_wd;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (err)  err_cnt  = err_cnt + 1;
    end

    // Reference model: byte-addressed memory and the last load result.
    logic [7:0]  refmem [0:63];
    logic [31:0] ref_rdata = '0;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = {26'd0, a[5:2], 2'b00};
        return {refmem[b+3], refmem[b+2], refmem[b+1], refmem[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: drive request, wait for completion, compare with model.
    task automatic xact(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
        int          nb;
        int          b;
        int          lat;
        int          wr0;
        logic        mis;
        logic [31:0] ea;
        logic [31:0] v;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
        ea  = (nb == 1) ? a : (nb == 2) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
        b   = {26'd0, ea[5:0]};
        wr0 = wr_cnt;
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        while (!done && !err && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            chk("trap_err", {31'd0, err}, 32'd1);
            chk("trap_lat", lat, 0);
            chk("trap_done", {31'd0, done}, 32'd0);
            chk("trap_nowrite", wr_cnt, wr0);
            chk("trap_rdata", rdata, ref_rdata);
        end else
`endif
        begin
            chk("latency", lat, (w && nb < 4) ? 2 : 1);
            chk("done_busy", {31'd0, busy}, 32'd0);
            chk("err_low", {31'd0, err}, 32'd0);
            if (w) begin
                for (int i = 0; i < nb; i++) refmem[b+i] = wd[8*i +: 8];
                chk("store_cnt", wr_cnt, wr0 + 1);
                chk("store_addr", last_wa, {ea[31:2], 2'b00});
                chk("store_word", tmem[ea[5:2]], ref_word(ea));
                chk("store_rdata_hold", rdata, ref_rdata);
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = refmem[b+i];
                if (sx && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (sx && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
                ref_rdata = v;
                chk("load_rdata", rdata, v);
                chk("load_nowrite", wr_cnt, wr0);
            end
        end
        @(posedge clk); #1;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_addr", mem_addr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          wr0;
        int          dn0;
        logic [31:0] a;
        logic [1:0]  sz;

        for (int i = 0; i < 64; i++) refmem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) tmem[i] = ref_word(32'(4 * i));

        rst = 1'b1; req = 1'b0; we = 1'b0; size = '0; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store, then byte RMW into the same word.
        xact(1'b1, 2'b10, 1'b0, 32'h0, 32'h1111_2222);
        chk("plan_sw_wd", last_wd, 32'h1111_2222);
        xact(1'b1, 2'b00, 1'b0, 32'h1, 32'h0000_00AB);
        chk("plan_sb_wd", last_wd, 32'h1111_AB22);

        // Extension cases on word 0x80112233.
        xact(1'b1, 2'b10, 1'b0, 32'h0, 32'h8011_2233);
        xact(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
        chk("plan_lb_s", rdata, 32'hFFFF_FF80);
        xact(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
        chk("plan_lb_u", rdata, 32'h0000_0080);
        xact(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        chk("plan_lh_s", rdata, 32'hFFFF_8011);
        xact(1'b0, 2'b10, 1'b1, 32'h0, 32'h0);
        chk("plan_lw", rdata, 32'h8011_2233);

        // Misaligned half load at 0x1.
        xact(1'b0, 2'b01, 1'b1, 32'h1, 32'h0);
`ifndef MISALIGN_TRAP_EN
        chk("plan_lh_mis", rdata, 32'h0000_2233);
`endif

        // Reset during the WR cycle of a half store.
        wr0 = wr_cnt; dn0 = done_cnt;
        req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h22; wdata = 32'hBEEF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rstwr_we_before", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwr_we_gated", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_rdata = '0;
        chk("rstwr_busy", {31'd0, busy}, 32'd0);
        chk("rstwr_rdata", rdata, 32'd0);
        chk("rstwr_nowrite", wr_cnt, wr0);
        chk("rstwr_mem", tmem[8], ref_word(32'h20));
        @(posedge clk); #1;
        chk("rstwr_nodone", done_cnt, dn0);
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

        // Request held high while busy: ignored until the done cycle.
        wr0 = wr_cnt; dn0 = done_cnt;
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h6; wdata = 32'h5A;
        @(posedge clk); #1;
        we = 1'b0; size = 2'b10; addr = 32'h4;
        @(posedge clk); #1;
        chk("hold_busy_wr", {31'd0, busy}, 32'd1);
        chk("hold_nodone", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        refmem[6] = 8'h5A;
        chk("hold_done1", {31'd0, done}, 32'd1);
        chk("hold_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        chk("hold_accept", {31'd0, busy}, 32'd1);
        chk("hold_one_write", wr_cnt, wr0 + 1);
        @(posedge clk); #1;
        ref_rdata = ref_word(32'h4);
        chk("hold_done2", {31'd0, done}, 32'd1);
        chk("hold_load", rdata, ref_rdata);
        @(posedge clk); #1;
        chk("hold_done_cnt", done_cnt, dn0 + 2);

        // Randomized mix of loads and stores.
        for (int n = 0; n < 60; n++) begin
            a  = ($urandom & 32'h0000_003F) | (32'($urandom_range(0, 15)) << 28);
            sz = 2'($urandom);
            xact(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

`ifndef MISALIGN_TRAP_EN
        chk("no_err_pulses", err_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
